// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg
//   Shared definitions for the UART transmit scheduler:
//   - parity-type codes carried on cfg_parity_type / parity_type
//   - bit positions inside the 12-bit PISO frame
//   - FSM state encodings
//   - build_frame(): assembles start/data/parity/stop bits for one byte
package uart_tx_sched_pkg;

    localparam int FRAME_W   = 12;

    // Frame bit positions; data occupies [8:1]
    localparam int BIT_START = 0;
    localparam int BIT_PAR   = 9;
    localparam int BIT_STOP1 = 10;
    localparam int BIT_STOP2 = 11;

    // Parity codes; 2'b00 and 2'b11 both mean "no parity bit"
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_WAIT = 2'b10
    } state_e;

    // In 7-bit mode data[7] is cleared before the parity reduction, so the
    // 8-bit XOR equals the parity over data[6:0]. Without parity the bit
    // position idles high like a stop bit.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [7:0] data,
        input logic       len8,
        input logic [1:0] ptype
    );
        logic [7:0]         d;
        logic               par;
        logic [FRAME_W-1:0] f;
        d = len8 ? data : {1'b0, data[6:0]};
        case (ptype)
            PAR_EVEN: par = ^d;
            PAR_ODD:  par = ~^d;
            default:  par = 1'b1;
        endcase
        f            = {FRAME_W{1'b1}};
        f[BIT_START] = 1'b0;
        f[8:1]       = d;
        f[BIT_PAR]   = par;
        f[BIT_STOP1] = 1'b1;
        f[BIT_STOP2] = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arb2.sv
// uart_rr_arb2
//   Two-way round-robin arbiter. With a single valid requester that one is
//   granted; with both valid the requester that did not win last is granted.
//   The pointer only moves when a transfer happens (en & grant_valid).
// Ports:
//   clk, arst          clock, asynchronous active-high reset
//   en                 acceptance window (scheduler idle)
//   req_valid[1:0]     requester valid flags
//   grant_valid        some requester is granted
//   grant_id           index of the granted requester
//   ready[1:0]         per-requester accept strobe (en & granted)
module uart_rr_arb2 (
    input  logic       clk,
    input  logic       arst,
    input  logic       en,
    input  logic [1:0] req_valid,
    output logic       grant_valid,
    output logic       grant_id,
    output logic [1:0] ready
);

    logic last_q;
    logic last_d;

    // Grant selection and pointer update
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        case (req_valid)
            2'b01: begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
            2'b11: begin
                grant_valid = 1'b1;
                grant_id    = ~last_q;
            end
            default: begin
                grant_valid = 1'b0;
                grant_id    = 1'b0;
            end
        endcase
        if (en && grant_valid) begin
            ready  = grant_id ? 2'b10 : 2'b01;
            last_d = grant_id;
        end else begin
            ready  = 2'b00;
            last_d = last_q;
        end
    end

    // Last-winner pointer; reset value 1 makes requester 0 win the first tie
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Shares the UART PISO transmitter between two byte requesters. A transfer
//   in IDLE latches the byte and the line config, builds the 12-bit frame and
//   raises send; SEND waits for the PISO to go active, WAIT waits for tx_done.
//   Both waits are guarded by watchdogs that abort with a one-cycle
//   err_timeout pulse. All outputs are registered except reqX_ready.
// Ports:
//   baud_clk, arst                          clock, async active-high reset
//   cfg_data_length/stop_bits/parity_type   live line config
//   req{0,1}_valid/data/ready               byte requesters
//   send, frame_out                         PISO start request and frame
//   data_length, stop_bits, parity_type     per-frame latched config
//   tx_active, tx_done                      PISO status
//   busy, grant_id, err_timeout             scheduler status
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int ACK_TIMEOUT  = 4,
    parameter int DONE_TIMEOUT = 16
) (
    input  logic               baud_clk,
    input  logic               arst,
    input  logic               cfg_data_length,
    input  logic               cfg_stop_bits,
    input  logic [1:0]         cfg_parity_type,
    input  logic               req0_valid,
    input  logic [7:0]         req0_data,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [7:0]         req1_data,
    output logic               req1_ready,
    output logic               send,
    output logic [FRAME_W-1:0] frame_out,
    output logic               data_length,
    output logic               stop_bits,
    output logic [1:0]         parity_type,
    input  logic               tx_active,
    input  logic               tx_done,
    output logic               busy,
    output logic               grant_id,
    output logic               err_timeout
);

    localparam logic [4:0] ACK_LAST  = 5'(ACK_TIMEOUT - 1);
    localparam logic [4:0] DONE_LAST = 5'(DONE_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d, cnt_inc;
    logic               send_q, send_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               dl_q, dl_d;
    logic               sb_q, sb_d;
    logic [1:0]         pt_q, pt_d;
    logic               busy_q, busy_d;
    logic               gid_q, gid_d;
    logic               err_q, err_d;

    logic               is_idle;
    logic               arb_valid;
    logic               arb_id;
    logic [1:0]         arb_ready;
    logic               xfer;
    logic [7:0]         sel_data;

    assign is_idle  = (state_q == ST_IDLE);
    assign xfer     = is_idle & arb_valid;
    assign sel_data = arb_id ? req1_data : req0_data;
    // Watchdog counter saturates instead of wrapping
    assign cnt_inc  = (cnt_q == 5'h1F) ? cnt_q : cnt_q + 5'd1;

    uart_rr_arb2 u_arb (
        .clk         (baud_clk),
        .arst        (arst),
        .en          (is_idle),
        .req_valid   ({req1_valid, req0_valid}),
        .grant_valid (arb_valid),
        .grant_id    (arb_id),
        .ready       (arb_ready)
    );

    assign req0_ready  = arb_ready[0];
    assign req1_ready  = arb_ready[1];
    assign send        = send_q;
    assign frame_out   = frame_q;
    assign data_length = dl_q;
    assign stop_bits   = sb_q;
    assign parity_type = pt_q;
    assign busy        = busy_q;
    assign grant_id    = gid_q;
    assign err_timeout = err_q;

    // State register
    always_ff @(posedge baud_clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; tx_done is not looked at while in SEND
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) state_d = ST_SEND;
                else      state_d = ST_IDLE;
            end
            ST_SEND: begin
                if (tx_active)              state_d = ST_WAIT;
                else if (cnt_q == ACK_LAST) state_d = ST_IDLE;
                else                        state_d = ST_SEND;
            end
            ST_WAIT: begin
                if (tx_done)                 state_d = ST_IDLE;
                else if (cnt_q == DONE_LAST) state_d = ST_IDLE;
                else                         state_d = ST_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; frame and config hold until the next transfer
    always_comb begin
        cnt_d   = cnt_inc;
        send_d  = send_q;
        frame_d = frame_q;
        dl_d    = dl_q;
        sb_d    = sb_q;
        pt_d    = pt_q;
        busy_d  = busy_q;
        gid_d   = gid_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 5'd0;
                if (xfer) begin
                    frame_d = build_frame(sel_data, cfg_data_length, cfg_parity_type);
                    dl_d    = cfg_data_length;
                    sb_d    = cfg_stop_bits;
                    pt_d    = cfg_parity_type;
                    gid_d   = arb_id;
                    send_d  = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    send_d  = 1'b0;
                end
            end
            ST_SEND: begin
                if (tx_active) begin
                    send_d = 1'b0;
                    cnt_d  = 5'd0;
                end else if (cnt_q == ACK_LAST) begin
                    send_d = 1'b0;
                    busy_d = 1'b0;
                    err_d  = 1'b1;
                    cnt_d  = 5'd0;
                end else begin
                    send_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (tx_done) begin
                    busy_d = 1'b0;
                    cnt_d  = 5'd0;
                end else if (cnt_q == DONE_LAST) begin
                    busy_d = 1'b0;
                    err_d  = 1'b1;
                    cnt_d  = 5'd0;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                send_d = 1'b0;
                busy_d = 1'b0;
                cnt_d  = 5'd0;
            end
        endcase
    end

    // Registered outputs, watchdog counter and latched frame config
    always_ff @(posedge baud_clk or posedge arst) begin
        if (arst) begin
            cnt_q   <= 5'd0;
            send_q  <= 1'b0;
            frame_q <= {FRAME_W{1'b1}};
            dl_q    <= 1'b1;
            sb_q    <= 1'b0;
            pt_q    <= 2'b00;
            busy_q  <= 1'b0;
            gid_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            send_q  <= send_d;
            frame_q <= frame_d;
            dl_q    <= dl_d;
            sb_q    <= sb_d;
            pt_q    <= pt_d;
            busy_q  <= busy_d;
            gid_q   <= gid_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched with a small PISO model. Expected frames are
// queued when requests are issued; a monitor pops and compares on each
// rising edge of send.
module tb_uart_tx_sched;

    logic        baud_clk;
    logic        arst;
    logic        cfg_data_length, cfg_stop_bits;
    logic [1:0]  cfg_parity_type;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        send;
    logic [11:0] frame_out;
    logic        data_length, stop_bits;
    logic [1:0]  parity_type;
    logic        tx_active, tx_done;
    logic        busy, grant_id, err_timeout;

    typedef struct {
        logic        gid;
        logic [11:0] frame;
        logic        dl;
        logic        sb;
        logic [1:0]  pt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   send_cnt = 0;
    int   neg_cnt  = 0;
    int   xfer_at  = -10;
    bit   piso_en  = 1'b1;
    int   piso_len = 6;
    int   pcnt     = 0;

    uart_tx_sched dut (
        .baud_clk        (baud_clk),
        .arst            (arst),
        .cfg_data_length (cfg_data_length),
        .cfg_stop_bits   (cfg_stop_bits),
        .cfg_parity_type (cfg_parity_type),
        .req0_valid      (req0_valid),
        .req0_data       (req0_data),
        .req0_ready      (req0_ready),
        .req1_valid      (req1_valid),
        .req1_data       (req1_data),
        .req1_ready      (req1_ready),
        .send            (send),
        .frame_out       (frame_out),
        .data_length     (data_length),
        .stop_bits       (stop_bits),
        .parity_type     (parity_type),
        .tx_active       (tx_active),
        .tx_done         (tx_done),
        .busy            (busy),
        .grant_id        (grant_id),
        .err_timeout     (err_timeout)
    );

    initial begin
        baud_clk = 1'b0;
        forever #5 baud_clk = ~baud_clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic gid, input logic [11:0] frame);
        exp_t e;
        e.gid   = gid;
        e.frame = frame;
        e.dl    = cfg_data_length;
        e.sb    = cfg_stop_bits;
        e.pt    = cfg_parity_type;
        exp_q.push_back(e);
    endtask

    // Called at negedge+1; returns at negedge+1 after the transfer edge
    task automatic send_req(input logic id, input logic [7:0] d);
        bit got;
        got = 1'b0;
        if (id) begin req1_data = d; req1_valid = 1'b1; end
        else    begin req0_data = d; req0_valid = 1'b1; end
        for (int i = 0; i < 60 && !got; i++) begin
            #1;
            if (id ? req1_ready : req0_ready) got = 1'b1;
            @(negedge baud_clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("req_accepted", 32'(got), 32'd1);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge baud_clk); #1;
            if (tx_done) seen = 1'b1;
        end
        chk("tx_done_seen", 32'(seen), 32'd1);
        @(negedge baud_clk); #1;
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("send_after_done", 32'(send), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_send"},   32'(send), 32'd0);
        chk({tag, "_frame"},  32'(frame_out), 32'hFFF);
        chk({tag, "_cfg"},    32'({data_length, stop_bits, parity_type}), 32'b1000);
        chk({tag, "_busy"},   32'(busy), 32'd0);
        chk({tag, "_gid"},    32'(grant_id), 32'd0);
        chk({tag, "_err"},    32'(err_timeout), 32'd0);
    endtask

    // PISO model: goes active the negedge after send, pulses tx_done after piso_len cycles
    initial begin
        tx_active = 1'b0;
        tx_done   = 1'b0;
        forever begin
            @(negedge baud_clk);
            if (arst) begin
                pcnt = 0; tx_active = 1'b0; tx_done = 1'b0;
            end else if (tx_done) begin
                tx_done = 1'b0;
            end else if (pcnt != 0) begin
                pcnt--;
                if (pcnt == 0) begin tx_active = 1'b0; tx_done = 1'b1; end
            end else if (piso_en && send) begin
                tx_active = 1'b1;
                pcnt      = piso_len;
            end
        end
    end

    // Monitor: compares each new frame against the scoreboard head
    initial begin
        logic prev_send;
        exp_t e;
        prev_send = 1'b0;
        forever begin
            @(negedge baud_clk); #3;
            if (arst) begin
                prev_send = 1'b0;
            end else begin
                if (send && !prev_send) begin
                    send_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_send", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_out", 32'(frame_out), 32'(e.frame));
                        chk("grant_id", 32'(grant_id), 32'(e.gid));
                        chk("frame_cfg", 32'({data_length, stop_bits, parity_type}),
                            32'({e.dl, e.sb, e.pt}));
                        chk("send_latency", 32'(neg_cnt), 32'(xfer_at + 1));
                    end
                end
                if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) xfer_at = neg_cnt;
                prev_send = send;
            end
            neg_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  start;
        int  n;
        bit  seen;
        arst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 8'h00; req1_data = 8'h00;
        cfg_data_length = 1'b1; cfg_stop_bits = 1'b0; cfg_parity_type = 2'b00;
        repeat (3) @(negedge baud_clk);
        #1;
        chk_reset_outputs("rst");
        arst = 1'b0;
        @(negedge baud_clk); #1;
        chk_reset_outputs("post_rst");

        // Both valid from reset: 0,1,0,1
        push_exp(1'b0, 12'hE78); push_exp(1'b1, 12'hF4A);
        push_exp(1'b0, 12'hE78); push_exp(1'b1, 12'hF4A);
        start = send_cnt;
        req0_data = 8'h3C; req1_data = 8'hA5;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 300 && send_cnt < start + 4; i++) begin
            @(negedge baud_clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr_frames", 32'(send_cnt - start), 32'd4);
        wait_done();

        // 8-bit, even parity, two stop bits, 0xD5
        cfg_data_length = 1'b1; cfg_stop_bits = 1'b1; cfg_parity_type = 2'b10;
        push_exp(1'b0, 12'hFAA);
        send_req(1'b0, 8'hD5);
        wait_done();

        // 7-bit, odd parity, 0xFF
        cfg_data_length = 1'b0; cfg_stop_bits = 1'b0; cfg_parity_type = 2'b01;
        push_exp(1'b1, 12'hCFE);
        send_req(1'b1, 8'hFF);
        wait_done();

        // PISO never goes active: ACK watchdog
        cfg_data_length = 1'b1; cfg_stop_bits = 1'b0; cfg_parity_type = 2'b00;
        piso_en = 1'b0;
        push_exp(1'b0, 12'hF02);
        send_req(1'b0, 8'h81);
        n = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (err_timeout) seen = 1'b1;
            else begin
                if (send) n++;
                @(negedge baud_clk); #1;
            end
        end
        chk("ack_err_pulse", 32'(seen), 32'd1);
        chk("ack_send_cycles", 32'(n), 32'd4);
        chk("ack_send_low", 32'(send), 32'd0);
        chk("ack_busy_low", 32'(busy), 32'd0);
        @(negedge baud_clk); #1;
        chk("ack_err_one_cycle", 32'(err_timeout), 32'd0);
        piso_en = 1'b1;
        push_exp(1'b1, 12'hEB4);
        send_req(1'b1, 8'h5A);
        wait_done();

        // Async reset in WAIT
        push_exp(1'b1, 12'hE66);
        send_req(1'b1, 8'h33);
        @(negedge baud_clk); #1;
        @(negedge baud_clk); #1;
        chk("in_wait_busy", 32'(busy), 32'd1);
        chk("in_wait_send", 32'(send), 32'd0);
        arst = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        @(negedge baud_clk); #1;
        arst = 1'b0;
        @(negedge baud_clk); #1;
        push_exp(1'b0, 12'hE1E);
        req0_data = 8'h0F; req1_data = 8'h77;
        req0_valid = 1'b1; req1_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (req0_ready || req1_ready) seen = 1'b1;
            @(negedge baud_clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("post_rst_accept", 32'(seen), 32'd1);
        wait_done();

        // Parity config changed mid-frame
        cfg_parity_type = 2'b10;
        push_exp(1'b0, 12'hE02);
        send_req(1'b0, 8'h01);
        @(negedge baud_clk); #1;
        cfg_parity_type = 2'b01;
        @(negedge baud_clk); #1;
        chk("inflight_parity", 32'(parity_type), 32'b10);
        wait_done();
        chk("held_parity", 32'(parity_type), 32'b10);
        chk("held_frame", 32'(frame_out), 32'hE02);
        push_exp(1'b0, 12'hE00);
        send_req(1'b0, 8'h00);
        wait_done();

        repeat (3) @(negedge baud_clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
